entrada_serial: RTL and testbench

- Serial-to-parallel audio receiver. It is the capture-side counterpart of the 16-bit PCM serializer in the audio path.
- It samples one bit per bclk edge from the microphone/codec data line, starting at a frame-start strobe `act`.
- It assembles WIDTH bits into a parallel word and presents that word with a one-cycle `done` pulse to the downstream PCM buffer.
- It detects short frames and counts them.

---
 rtl/entrada_serial.sv | 109 ++++++++++
 tb/tb_entrada_serial.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/entrada_serial.sv
// Serial-to-parallel audio receiver: assembles WIDTH bits starting at a frame-start
// strobe, pulses done with the word, and flags/counts frames aborted by an early act.
module entrada_serial #(
  parameter int unsigned WIDTH     = 16,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic             bclk,
  input  logic             reset,
  input  logic             enable,
  input  logic             act,
  input  logic             d_in,
  output logic [WIDTH-1:0] data,
  output logic             done,
  output logic             busy,
  output logic             frame_err,
  output logic [7:0]       err_count
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             frame_err_q, frame_err_d;
  logic [7:0]       err_count_q, err_count_d;
  logic [WIDTH-1:0] sr_shift;

  // Shift register contents after capturing d_in in the configured bit order
  always_comb begin
    if (MSB_FIRST) sr_shift = {sr_q[WIDTH-2:0], d_in};
    else           sr_shift = {d_in, sr_q[WIDTH-1:1]};
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sr_d        = sr_q;
    data_d      = data_q;
    done_d      = 1'b0;
    busy_d      = busy_q;
    frame_err_d = 1'b0;
    err_count_d = err_count_q;

    if (enable) begin
      unique case (state_q)
        IDLE: begin
          if (act) begin
            sr_d    = sr_shift;
            cnt_d   = CW'(1);
            state_d = SHIFT;
            busy_d  = 1'b1;
          end
        end
        SHIFT: begin
          sr_d = sr_shift;
          if (act) begin
            // Early act aborts the partial word and restarts on this bit
            frame_err_d = 1'b1;
            if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
            cnt_d = CW'(1);
          end else if (cnt_q == CW'(WIDTH - 1)) begin
            data_d  = sr_shift;
            done_d  = 1'b1;
            cnt_d   = '0;
            state_d = IDLE;
            busy_d  = 1'b0;
          end else begin
            cnt_d = CW'(cnt_q + CW'(1));
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge bclk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      sr_q        <= '0;
      data_q      <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sr_q        <= sr_d;
      data_q      <= data_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      frame_err_q <= frame_err_d;
      err_count_q <= err_count_d;
    end
  end

  assign data      = data_q;
  assign done      = done_q;
  assign busy      = busy_q;
  assign frame_err = frame_err_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_entrada_serial.sv
// Bench for entrada_serial: LSB-first and MSB-first instances fed the same serial
// stream, checked against directed expectations and a frame-level reference model.
module tb_entrada_serial;
  localparam int unsigned W = 16;

  logic bclk = 1'b0;
  logic reset, enable, act, d_in;
  logic [W-1:0] data_l, data_m;
  logic done_l, done_m, busy_l, busy_m, fe_l, fe_m;
  logic [7:0] ec_l, ec_m;

  int total = 0;
  int bad   = 0;

  // Reference model: bits of the current frame, completed words, pulses, error count
  logic     mq[$];
  bit       m_in;
  logic [W-1:0] m_data_l, m_data_m;
  bit       m_done, m_fe, m_busy;
  int       m_errs;

  always #5 bclk = ~bclk;

  entrada_serial #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .bclk(bclk), .reset(reset), .enable(enable), .act(act), .d_in(d_in),
    .data(data_l), .done(done_l), .busy(busy_l), .frame_err(fe_l), .err_count(ec_l));

  entrada_serial #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .bclk(bclk), .reset(reset), .enable(enable), .act(act), .d_in(d_in),
    .data(data_m), .done(done_m), .busy(busy_m), .frame_err(fe_m), .err_count(ec_m));

  task automatic model_clear();
    mq.delete();
    m_in = 0; m_data_l = '0; m_data_m = '0;
    m_done = 0; m_fe = 0; m_busy = 0; m_errs = 0;
  endtask

  // Drive one cycle of inputs, let the edge happen, then advance the model
  task automatic step(input logic en, input logic a, input logic d);
    enable = en; act = a; d_in = d;
    @(posedge bclk); #1;
    m_done = 0; m_fe = 0;
    if (en) begin
      if (a) begin
        if (m_in) begin
          m_fe = 1;
          m_errs = (m_errs < 255) ? m_errs + 1 : 255;
        end
        mq.delete();
        mq.push_back(d);
        m_in = 1;
      end else if (m_in) begin
        mq.push_back(d);
      end
      if (m_in && mq.size() == W) begin
        for (int i = 0; i < int'(W); i++) begin
          m_data_l[i]     = mq[i];
          m_data_m[W-1-i] = mq[i];
        end
        m_done = 1;
        m_in = 0;
        mq.delete();
      end
    end
    m_busy = m_in;
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = 1'b1; act = 1'b1; d_in = 1'b1;
    @(posedge bclk); #1;
    reset = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (data_l !== '0 || data_m !== '0) begin bad++; $display("FAIL reset_data got %h/%h want 0", data_l, data_m); end
    total++; if (done_l !== 1'b0 || done_m !== 1'b0) begin bad++; $display("FAIL reset_done got %b/%b want 0", done_l, done_m); end
    total++; if (busy_l !== 1'b0 || busy_m !== 1'b0) begin bad++; $display("FAIL reset_busy got %b/%b want 0", busy_l, busy_m); end
    total++; if (fe_l !== 1'b0 || fe_m !== 1'b0) begin bad++; $display("FAIL reset_ferr got %b/%b want 0", fe_l, fe_m); end
    total++; if (ec_l !== 8'd0 || ec_m !== 8'd0) begin bad++; $display("FAIL reset_errcnt got %0d/%0d want 0", ec_l, ec_m); end
  endtask

  task automatic test_normal();
    logic [15:0] w;
    w = 16'hA5C3;
    for (int i = 0; i < 16; i++) begin
      step(1'b1, i == 0, w[i]);
      total++; if (done_l !== (i == 15)) begin bad++; $display("FAIL normal_done bit=%0d got %b want %b", i, done_l, (i == 15)); end
      total++; if (busy_l !== (i != 15)) begin bad++; $display("FAIL normal_busy bit=%0d got %b want %b", i, busy_l, (i != 15)); end
      total++; if (fe_l !== 1'b0) begin bad++; $display("FAIL normal_ferr bit=%0d got %b want 0", i, fe_l); end
    end
    total++; if (data_l !== 16'hA5C3) begin bad++; $display("FAIL normal_data got %h want a5c3", data_l); end
    total++; if (data_m !== m_data_m) begin bad++; $display("FAIL normal_data_msb got %h want %h", data_m, m_data_m); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] words [3];
    logic [15:0] w;
    words[0] = 16'h1234; words[1] = 16'hFFFF; words[2] = 16'h0001;
    for (int k = 0; k < 3; k++) begin
      w = words[k];
      for (int i = 0; i < 16; i++) begin
        step(1'b1, i == 0, w[i]);
        total++; if (done_l !== (i == 15)) begin bad++; $display("FAIL b2b_done word=%0d bit=%0d got %b", k, i, done_l); end
        if (i == 15) begin
          total++; if (data_l !== w) begin bad++; $display("FAIL b2b_data word=%0d got %h want %h", k, data_l, w); end
        end
      end
    end
    total++; if (ec_l !== 8'd0) begin bad++; $display("FAIL b2b_errcnt got %0d want 0", ec_l); end
  endtask

  task automatic test_stall();
    logic [15:0] w;
    w = 16'h8001;
    for (int i = 0; i < 16; i++) begin
      step(1'b1, i == 0, w[i]);
      total++; if (done_l !== (i == 15) || fe_l !== 1'b0) begin bad++; $display("FAIL stall_pulses bit=%0d got done=%b ferr=%b", i, done_l, fe_l); end
      if (i == 7) begin
        for (int s = 0; s < 3; s++) begin
          step(1'b0, 1'b1, 1'($urandom));
          total++; if (done_l !== 1'b0 || fe_l !== 1'b0 || busy_l !== 1'b1) begin bad++; $display("FAIL stall_hold cyc=%0d got done=%b ferr=%b busy=%b", s, done_l, fe_l, busy_l); end
          total++; if (data_l !== 16'h0001) begin bad++; $display("FAIL stall_data_hold got %h want 0001", data_l); end
        end
      end
    end
    total++; if (data_l !== 16'h8001) begin bad++; $display("FAIL stall_data got %h want 8001", data_l); end
  endtask

  task automatic test_short_frame();
    logic [15:0] w;
    for (int i = 0; i < 7; i++) begin
      step(1'b1, i == 0, 1'($urandom));
      total++; if (fe_l !== 1'b0 || done_l !== 1'b0) begin bad++; $display("FAIL short_partial bit=%0d ferr=%b done=%b", i, fe_l, done_l); end
    end
    w = 16'h00FF;
    for (int i = 0; i < 16; i++) begin
      step(1'b1, i == 0, w[i]);
      total++; if (fe_l !== (i == 0)) begin bad++; $display("FAIL short_ferr bit=%0d got %b want %b", i, fe_l, (i == 0)); end
      total++; if (done_l !== (i == 15)) begin bad++; $display("FAIL short_done bit=%0d got %b", i, done_l); end
      total++; if (data_l !== ((i == 15) ? 16'h00FF : 16'h8001)) begin bad++; $display("FAIL short_data bit=%0d got %h", i, data_l); end
      total++; if (ec_l !== 8'd1) begin bad++; $display("FAIL short_errcnt bit=%0d got %0d want 1", i, ec_l); end
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] w;
    w = 16'h1234;
    for (int i = 0; i < 16; i++) step(1'b1, i == 0, w[i]);
    total++; if (data_l !== 16'h1234) begin bad++; $display("FAIL rmid_first got %h want 1234", data_l); end
    for (int i = 0; i < 5; i++) step(1'b1, i == 0, 1'($urandom));
    reset = 1'b1; enable = 1'b1; act = 1'b0; d_in = 1'b0;
    @(posedge bclk); #1;
    reset = 1'b0;
    model_clear();
    total++; if ({data_l, done_l, busy_l, fe_l, ec_l} !== '0) begin bad++; $display("FAIL rmid_outputs data=%h done=%b busy=%b ferr=%b ec=%0d", data_l, done_l, busy_l, fe_l, ec_l); end
    w = 16'hBEEF;
    for (int i = 0; i < 16; i++) begin
      step(1'b1, i == 0, w[i]);
      total++; if (done_l !== (i == 15) || fe_l !== 1'b0) begin bad++; $display("FAIL rmid_pulses bit=%0d done=%b ferr=%b", i, done_l, fe_l); end
    end
    total++; if (data_l !== 16'hBEEF) begin bad++; $display("FAIL rmid_data got %h want beef", data_l); end
  endtask

  task automatic test_msb_first();
    logic [15:0] w;
    w = 16'hA5C3;
    for (int i = 0; i < 16; i++) begin
      step(1'b1, i == 0, w[15-i]);
      total++; if (done_m !== (i == 15)) begin bad++; $display("FAIL msb_done bit=%0d got %b", i, done_m); end
    end
    total++; if (data_m !== 16'hA5C3) begin bad++; $display("FAIL msb_data got %h want a5c3", data_m); end
    total++; if (data_l !== m_data_l) begin bad++; $display("FAIL msb_lsbview got %h want %h", data_l, m_data_l); end
  endtask

  task automatic test_saturation();
    int exp_ec;
    exp_ec = int'(ec_l === 8'd0 ? 0 : -1);
    total++; if (exp_ec != 0) begin bad++; $display("FAIL sat_start got %0d want 0", ec_l); end
    exp_ec = 0;
    for (int k = 0; k < 262; k++) begin
      step(1'b1, 1'b1, 1'($urandom));
      if (k > 0) exp_ec = (exp_ec < 255) ? exp_ec + 1 : 255;
      total++; if (fe_l !== (k > 0)) begin bad++; $display("FAIL sat_ferr k=%0d got %b want %b", k, fe_l, (k > 0)); end
      total++; if (ec_l !== 8'(exp_ec) || ec_m !== 8'(exp_ec)) begin bad++; $display("FAIL sat_errcnt k=%0d got %0d/%0d want %0d", k, ec_l, ec_m, exp_ec); end
    end
    total++; if (ec_l !== 8'd255) begin bad++; $display("FAIL sat_final got %0d want 255", ec_l); end
  endtask

  task automatic test_random();
    int len, sent;
    logic en;
    do_reset();
    for (int f = 0; f < 40; f++) begin
      len = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 15)) : 16;
      sent = 0;
      while (sent < len) begin
        en = ($urandom_range(0, 3) != 0);
        step(en, (sent == 0) ? 1'b1 : (en ? 1'b0 : 1'($urandom)), 1'($urandom));
        if (en) sent++;
        total++; if (done_l !== m_done || done_m !== m_done) begin bad++; $display("FAIL rand_done f=%0d got %b/%b want %b", f, done_l, done_m, m_done); end
        total++; if (fe_l !== m_fe || fe_m !== m_fe) begin bad++; $display("FAIL rand_ferr f=%0d got %b/%b want %b", f, fe_l, fe_m, m_fe); end
        total++; if (busy_l !== m_busy || busy_m !== m_busy) begin bad++; $display("FAIL rand_busy f=%0d got %b/%b want %b", f, busy_l, busy_m, m_busy); end
        total++; if (data_l !== m_data_l || data_m !== m_data_m) begin bad++; $display("FAIL rand_data f=%0d got %h/%h want %h/%h", f, data_l, data_m, m_data_l, m_data_m); end
        total++; if (ec_l !== 8'(m_errs)) begin bad++; $display("FAIL rand_errcnt f=%0d got %0d want %0d", f, ec_l, m_errs); end
      end
      for (int g = $urandom_range(0, 2); g > 0; g--) step(1'b1, 1'b0, 1'($urandom));
    end
  endtask

  initial begin
    reset = 1'b0; enable = 1'b0; act = 1'b0; d_in = 1'b0;
    model_clear();
    @(posedge bclk); #1;
    test_reset();
    test_normal();
    test_back_to_back();
    test_stall();
    test_short_frame();
    test_reset_mid();
    test_msb_first();
    test_saturation();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
